// File: rtl/uart_rx_with_buffer.sv
// uart_rx_with_buffer: serial receive path for the 115200-baud link.
// Oversamples rx, reassembles LSB-first bytes and stores them in a
// show-ahead FIFO that core logic drains with rd_en.
//
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames with even parity).
// Without it the frame is 8N1 and parity_err is tied low.
//
// Ports:
//   clk        system clock, posedge
//   rst        asynchronous active-high reset
//   rx         asynchronous serial input, idle high
//   rd_en      pop the head byte (ignored while empty)
//   rd_data    head byte, 0 when empty (registered)
//   empty      FIFO holds no bytes (registered)
//   count      number of stored bytes (registered)
//   overflow   sticky: a received byte was dropped on a full FIFO
//   frame_err  one-cycle pulse: stop bit sampled low
//   parity_err one-cycle pulse: parity mismatch (0 without the macro)
module uart_rx_with_buffer #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    input  logic                        rd_en,
    output logic [7:0]                  rd_data,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        frame_err,
    output logic                        parity_err
);
    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    // Two-stage synchronizer, both stages reset to the idle level
    logic sync1_q, rxs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs_q   <= sync1_q;
        end
    end

    // Receive FSM state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             frame_err_q, frame_err_d;
    logic             push_c;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state: every timed state counts down to 0, then acts on rxs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        data_d       = data_q;
        frame_err_d  = 1'b0;
        push_c       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (state_q != S_IDLE && state_q != S_WAIT_HIGH && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        cnt_d   = HALF_LOAD;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    if (!rxs_q) begin
                        cnt_d     = FULL_LOAD;
                        idx_d     = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_IDLE;  // glitch, not a start bit
                    end
                end
                S_DATA: begin
                    data_d[idx_q] = rxs_q;
                    cnt_d         = FULL_LOAD;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    cnt_d   = FULL_LOAD;
                    state_d = S_STOP;
                    if (rxs_q != ^data_q) begin
                        par_bad_d    = 1'b1;
                        parity_err_d = 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (rxs_q) begin
`ifdef UART_RX_PARITY_EN
                        push_c = !par_bad_q;
`else
                        push_c = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO storage and pointers
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic [CW-1:0]    count_q, count_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             do_push, do_pop, full;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // A pop frees a slot in the same cycle, so push+pop on a full FIFO is legal
    always_comb begin
        full       = (count_q == FULL_CNT);
        do_pop     = rd_en && (count_q != '0);
        do_push    = push_c && (!full || do_pop);
        overflow_d = overflow_q | (push_c && full && !do_pop);
        rd_ptr_inc = rd_ptr_q + PTR_W'(1);
        wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop ? rd_ptr_inc : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        // Registered show-ahead head: bypass the incoming byte when it becomes head
        if (count_d == '0) begin
            rd_data_d = '0;
        end else if (do_pop) begin
            rd_data_d = (count_q == CW'(1)) ? data_q : mem_q[rd_ptr_inc];
        end else if (count_q == '0) begin
            rd_data_d = data_q;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    assign rd_data   = rd_data_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
